uart_hex_sample_loader: RTL and testbench

UART_HEX_SAMPLE_LOADER -- requirements
Module: uart_hex_sample_loader

---
 rtl/sd_uart_pkg.sv | 41 ++++
 rtl/sample_fifo.sv | 62 ++++++
 rtl/uart_hex_sample_loader.sv | 145 ++++++++++++++
 tb/tb_uart_hex_sample_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_uart_pkg.sv
`default_nettype none
// ============================================================================
// sd_uart_pkg : ASCII constants, parser states and hex helpers for the UART
//               sample path (shared with the hex transmitter)
// Revision    : 1.0
// ============================================================================
package sd_uart_pkg;

    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_9       = 8'h39;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_F = 8'h46;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_F = 8'h66;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGITS  = 2'd1,
        ST_EOL     = 2'd2,
        ST_DISCARD = 2'd3
    } parse_state_t;

    function automatic logic is_hex_digit(input logic [7:0] c);
        return ((c >= ASCII_0) && (c <= ASCII_9)) ||
               ((c >= ASCII_UPPER_A) && (c <= ASCII_UPPER_F)) ||
               ((c >= ASCII_LOWER_A) && (c <= ASCII_LOWER_F));
    endfunction

    function automatic logic is_eol(input logic [7:0] c);
        return (c == ASCII_LF) || (c == ASCII_CR);
    endfunction

    // Letters of either case carry value (low nibble + 9); only valid for hex digits.
    function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
        return (c <= ASCII_9) ? c[3:0] : (c[3:0] + 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// sample_fifo : single-clock sample FIFO with registered read data and level
// Revision    : 1.0
// ============================================================================
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            pop_data <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr   <= rd_ptr + AW'(1);
                pop_data <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_hex_sample_loader.sv
`default_nettype none
// ============================================================================
// uart_hex_sample_loader : parses ASCII hex lines from a UART into DAC samples
// Revision               : 1.0
// ============================================================================
module uart_hex_sample_loader
    import sd_uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SAMPLE_BITS = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rvalid,
    output logic                          rready,
    input  logic [7:0]                    rdata,
    input  logic                          dac_ready,
    output logic [SAMPLE_BITS-1:0]        dac_input,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          parse_err,
    input  logic                          clear
);
    localparam int NUM_DIGITS = SAMPLE_BITS / 4;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

    parse_state_t           state, state_next;
    logic [SAMPLE_BITS-1:0] shreg, shreg_next;
    logic [CNT_W-1:0]       count, count_next;
    logic                   push_pend, push_next;
    logic                   err_event;
    logic                   accept;
    logic                   byte_hex;
    logic                   byte_eol;
    logic [3:0]             nib;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;

    assign accept   = rvalid & rready;
    assign byte_hex = is_hex_digit(rdata);
    assign byte_eol = is_eol(rdata);
    assign nib      = hex_to_nibble(rdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            count     <= '0;
            push_pend <= 1'b0;
            rready    <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            count     <= count_next;
            push_pend <= push_next;
            rready    <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        count_next = count;
        push_next  = 1'b0;
        err_event  = 1'b0;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (byte_hex) begin
                        shreg_next = SAMPLE_BITS'(nib);
                        count_next = CNT_W'(1);
                        state_next = (NUM_DIGITS == 1) ? ST_EOL : ST_DIGITS;
                    end else if (!byte_eol) begin
                        err_event  = 1'b1;
                        state_next = ST_DISCARD;
                    end
                end
                ST_DIGITS: begin
                    if (byte_hex) begin
                        shreg_next = (shreg << 4) | SAMPLE_BITS'(nib);
                        count_next = count + CNT_W'(1);
                        if (count == CNT_W'(NUM_DIGITS - 1)) begin
                            state_next = ST_EOL;
                        end
                    end else begin
                        err_event  = 1'b1;
                        state_next = byte_eol ? ST_IDLE : ST_DISCARD;
                    end
                end
                ST_EOL: begin
                    if (byte_eol) begin
                        push_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        err_event  = 1'b1;
                        state_next = ST_DISCARD;
                    end
                end
                default: begin
                    if (byte_eol) begin
                        state_next = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // The assembled sample stays in shreg for the push cycle: any new digit
    // that arrives then is loaded on the same edge that writes the FIFO.
    assign pop = dac_ready & ~fifo_empty;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_pend),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (dac_input),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fill_level)
    );

    // Sticky flags: a new event takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            parse_err <= 1'b0;
        end else begin
            if (push_pend & fifo_full & ~pop) overflow <= 1'b1;
            else if (clear)                   overflow <= 1'b0;
            if (dac_ready & fifo_empty)       underflow <= 1'b1;
            else if (clear)                   underflow <= 1'b0;
            if (err_event)                    parse_err <= 1'b1;
            else if (clear)                   parse_err <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_hex_sample_loader.sv
`default_nettype none
// ============================================================================
// tb_uart_hex_sample_loader : scoreboard bench with a line-level reference model
// Revision                  : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_hex_sample_loader;
    localparam int FIFO_DEPTH  = 16;
    localparam int SAMPLE_BITS = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rvalid = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic        dac_ready = 1'b0;
    logic        clear = 1'b0;
    logic        rready;
    logic [23:0] dac_input;
    logic [4:0]  fill_level;
    logic        overflow, underflow, parse_err;

    int checks = 0;
    int fails  = 0;

    int  model_q[$];
    int  exp_q[$];
    int  last_out = 0;
    bit  m_ovf = 0, m_unf = 0, m_err = 0;
    byte unsigned line_buf[$];

    always #5 clk = ~clk;

    uart_hex_sample_loader #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SAMPLE_BITS (SAMPLE_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .dac_ready  (dac_ready),
        .dac_input  (dac_input),
        .fill_level (fill_level),
        .overflow   (overflow),
        .underflow  (underflow),
        .parse_err  (parse_err),
        .clear      (clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: one sample expected on dac_input the cycle after each dac_ready pulse.
    bit pend = 0;
    int mon_exp;
    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL dac_unexpected: actual=0x%0h required=none", dac_input);
            end else begin
                mon_exp = exp_q.pop_front();
                check("dac_input", {8'h00, dac_input}, mon_exp);
            end
        end
        pend = dac_ready && !rst;
    end

    // ---------------- reference model (line level) ----------------
    function automatic bit is_hex(input byte unsigned c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic int hex_val(input byte unsigned c);
        if (c <= "9") return c - "0";
        if (c <= "F") return c - "A" + 10;
        return c - "a" + 10;
    endfunction

    task automatic model_pop();
        if (model_q.size() > 0) last_out = model_q.pop_front();
        else                    m_unf = 1;
        exp_q.push_back(last_out);
    endtask

    task automatic model_push(input int v);
        if (model_q.size() == FIFO_DEPTH) m_ovf = 1;
        else                              model_q.push_back(v);
    endtask

    // A line of exactly six hex digits yields a sample; empty lines are ignored;
    // anything else is a malformed line.
    task automatic model_line();
        bit ok;
        int v;
        if (line_buf.size() == 0) return;
        ok = (line_buf.size() == SAMPLE_BITS / 4);
        v  = 0;
        foreach (line_buf[i]) begin
            if (!is_hex(line_buf[i])) ok = 0;
            else v = v * 16 + hex_val(line_buf[i]);
        end
        if (ok) model_push(v);
        else    m_err = 1;
    endtask

    // ---------------- stimulus ----------------
    task automatic set_line(input string s);
        line_buf.delete();
        for (int i = 0; i < s.len(); i++) line_buf.push_back(s[i]);
    endtask

    task automatic send_byte(input byte unsigned b, input int gap);
        rvalid = 1'b1;
        rdata  = b;
        @(posedge clk); #1;
        rvalid = 1'b0;
        rdata  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // term: 0=LF 1=CR 2=CRLF. pop_at_push pulses dac_ready in the push cycle.
    task automatic send_line(input int term, input bit pop_at_push, input bit gaps);
        foreach (line_buf[i]) send_byte(line_buf[i], gaps ? $urandom_range(0, 2) : 0);
        if (term == 2) begin
            send_byte(8'h0D, 0);
            send_byte(8'h0A, 0);
        end else begin
            send_byte(term == 1 ? 8'h0D : 8'h0A, 0);
        end
        if (pop_at_push && term != 2) begin
            dac_ready = 1'b1;
            model_pop();
        end
        model_line();
        @(posedge clk); #1;
        dac_ready = 1'b0;
    endtask

    task automatic pulse_dac();
        dac_ready = 1'b1;
        model_pop();
        @(posedge clk); #1;
        dac_ready = 1'b0;
    endtask

    task automatic do_clear(input bit with_dac);
        clear = 1'b1;
        m_ovf = 0; m_unf = 0; m_err = 0;
        if (with_dac) begin
            dac_ready = 1'b1;
            model_pop();
        end
        @(posedge clk); #1;
        clear = 1'b0;
        dac_ready = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".fill_level"}, {27'd0, fill_level}, model_q.size());
        check({tag, ".overflow"},  {31'd0, overflow},  {31'd0, m_ovf});
        check({tag, ".underflow"}, {31'd0, underflow}, {31'd0, m_unf});
        check({tag, ".parse_err"}, {31'd0, parse_err}, {31'd0, m_err});
    endtask

    task automatic drain();
        while (model_q.size() > 0) pulse_dac();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".rready"}, {31'd0, rready}, 0);
        check({tag, ".dac_input"}, {8'd0, dac_input}, 0);
        check({tag, ".fill_level"}, {27'd0, fill_level}, 0);
        check({tag, ".flags"}, {29'd0, overflow, underflow, parse_err}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string charset;
        int    kind, term, len, v;
        charset = "0123456789aFcEgG z!-";

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        set_line("00ABCD"); send_line(0, 0, 0);
        check_state("basic_push");
        pulse_dac();
        check_state("basic_pop");

        set_line("7fffff"); send_line(2, 0, 0);
        set_line("80000a"); send_line(2, 0, 0);
        check_state("crlf_lines");
        pulse_dac(); pulse_dac();

        set_line("12G456");  send_line(0, 0, 0);
        set_line("1234567"); send_line(0, 0, 0);
        set_line("ABC");     send_line(0, 0, 0);
        check_state("malformed");
        do_clear(0);
        check_state("cleared");

        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            set_line($sformatf("%06x", 24'h100000 + i * 24'h0111));
            send_line(i % 2, 0, 0);
        end
        check_state("overflow");
        do_clear(0);
        set_line("abcdef"); send_line(0, 1, 0);
        check_state("full_push_pop");
        drain();
        check_state("drained");

        set_line("123456"); send_line(0, 0, 0);
        pulse_dac();
        pulse_dac();
        check_state("underflow");
        do_clear(1);
        check_state("clear_vs_event");
        do_clear(0);

        set_line("12AB");
        foreach (line_buf[i]) send_byte(line_buf[i], 0);
        rst = 1'b1;
        model_q.delete();
        last_out = 0; m_ovf = 0; m_unf = 0; m_err = 0;
        @(posedge clk); #1;
        check_reset_values("midline_reset");
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        set_line("000001"); send_line(0, 0, 0);
        check_state("after_reset");
        pulse_dac();

        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            term = $urandom_range(0, 2);
            line_buf.delete();
            if (kind <= 4) begin
                for (int d = 0; d < 6; d++) begin
                    v = $urandom_range(0, 15);
                    if (v < 10)            line_buf.push_back(8'("0" + v));
                    else if ($urandom % 2) line_buf.push_back(8'("A" + v - 10));
                    else                   line_buf.push_back(8'("a" + v - 10));
                end
            end else if (kind <= 7) begin
                len = $urandom_range(1, 8);
                for (int d = 0; d < len; d++) line_buf.push_back(charset[$urandom_range(0, charset.len() - 1)]);
            end
            send_line(term, ($urandom % 4 == 0), $urandom % 2);
            repeat ($urandom_range(0, 2)) if ($urandom % 2) pulse_dac();
            if (it % 10 == 9) begin
                check_state("random");
                if ($urandom % 2) do_clear($urandom % 2);
            end
        end
        drain();
        check_state("final");
        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
